// File: rtl/convolver_stream.sv
// rtl/convolver_stream.sv - streaming KxK convolver with line buffers, weight store and frame control
module convolver_stream #(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_SIZE  = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH+$clog2(KERNEL_SIZE*KERNEL_SIZE),
  localparam int ADDR_WIDTH = (KERNEL_SIZE*KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE*KERNEL_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         weight_we,
  input  logic [ADDR_WIDTH-1:0]        weight_addr,
  input  logic signed [DATA_WIDTH-1:0] weight_data,
  output logic                         weight_err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  out_data,
  output logic                         out_last,
  output logic                         busy
);

  localparam int N       = IMAGE_SIZE;
  localparam int K       = KERNEL_SIZE;
  localparam int S       = STRIDE;
  localparam int KK      = K*K;
  localparam int CW      = (N > 1) ? $clog2(N) : 1;
  localparam int M       = (N-K)/S + 1;
  // row/col index of the pixel that completes the final window of a frame
  localparam int LAST_RC = K-1 + (M-1)*S;
  localparam int PW      = 2*DATA_WIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                row_q, col_q;
  logic                         accept, last_px, wr_bad, wr_ok;
  logic                         win_done, win_last;
  logic signed [DATA_WIDTH-1:0] weights [KK];
  logic signed [DATA_WIDTH-1:0] win_q   [K][K];
  logic signed [DATA_WIDTH-1:0] nxt_win [K][K];
  logic signed [DATA_WIDTH-1:0] new_col [K];
  logic signed [PW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  acc;

  // a pending result blocks input only until downstream takes it
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_px  = (row_q == CW'(N-1)) && (col_q == CW'(N-1));
  assign busy     = (state_q == RUN);

  // the cycle that accepts the first pixel already counts as RUN for weight writes
  assign wr_bad = weight_we && ((state_q == RUN) || accept || (32'(weight_addr) >= KK));
  assign wr_ok  = weight_we && !wr_bad;

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // frame FSM: enter RUN on any accepted pixel, leave on the frame's final pixel
  always_comb begin
    state_d = state_q;
    if (accept) state_d = last_px ? IDLE : RUN;
  end

  // raster position of the next pixel to arrive
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      if (col_q == CW'(N-1)) begin
        col_q <= '0;
        row_q <= (row_q == CW'(N-1)) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // weight store, writable only between frames
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < KK; i++) weights[i] <= '0;
      weight_err <= 1'b0;
    end else begin
      weight_err <= wr_bad;
      if (wr_ok) weights[weight_addr] <= weight_data;
    end
  end

  // column entering the window: K-1 older rows from the line buffers plus the live pixel
  generate
    if (K > 1) begin : g_lines
      logic signed [DATA_WIDTH-1:0] lb [K-1][N];

      // line buffers age one row per visit to a column; contents are never reset
      always_ff @(posedge clk) begin
        if (accept) begin
          for (int i = 0; i < K-2; i++) lb[i][col_q] <= lb[i+1][col_q];
          lb[K-2][col_q] <= in_data;
        end
      end

      // read the stored rows above the current column
      always_comb begin
        for (int i = 0; i < K-1; i++) new_col[i] = lb[i][col_q];
        new_col[K-1] = in_data;
      end
    end else begin : g_nolines
      // a 1x1 kernel needs no row history
      always_comb begin
        new_col[0] = in_data;
      end
    end
  endgenerate

  // window after the shift that the current pixel would cause
  always_comb begin
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K; kc++) begin
        if (kc == K-1) nxt_win[kr][kc] = new_col[kr];
        else           nxt_win[kr][kc] = win_q[kr][kc+1];
      end
    end
  end

  // window registers shift left by one column per accepted pixel
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++)
          win_q[kr][kc] <= nxt_win[kr][kc];
    end
  end

  // full-precision dot product of the post-shift window with the weights
  always_comb begin
    acc  = '0;
    prod = '0;
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K; kc++) begin
        prod = weights[kr*K+kc] * nxt_win[kr][kc];
        acc  = acc + ACC_WIDTH'(prod);
      end
    end
  end

  // does the current pixel close a window on the stride grid, and is it the frame's last one
  always_comb begin
    int r, c;
    r        = 32'(row_q);
    c        = 32'(col_q);
    win_done = (r >= K-1) && (c >= K-1) && (((r-K+1) % S) == 0) && (((c-K+1) % S) == 0);
    win_last = (r == LAST_RC) && (c == LAST_RC);
  end

  // single result register; holds while downstream stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept && win_done) begin
      out_valid <= 1'b1;
      out_data  <= acc;
      out_last  <= win_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_convolver_stream.sv
// tb/tb_convolver_stream.sv - self-checking bench for convolver_stream in three configurations
module tb_convolver_stream;

  logic        clk = 1'b0;
  logic        rstn;
  logic        weight_we;
  logic [4:0]  weight_addr;
  logic [15:0] weight_data;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;
  int          sel;
  logic [2:0]  iv_v, we_v;

  logic        a_err, a_rdy, a_ov, a_ol, a_busy;
  logic        s_err, s_rdy, s_ov, s_ol, s_busy;
  logic        b_err, b_rdy, b_ov, b_ol, b_busy;
  logic [35:0] a_od, s_od;
  logic [36:0] b_od;

  logic               m_err, m_rdy, m_ov, m_ol, m_busy;
  logic signed [36:0] m_od;

  int     n_chk = 0;
  int     n_fail = 0;
  longint cyc = 0;

  int     cn, ck, cs;
  int     pix [1568];
  longint wt [25];
  longint acc_cyc [1568];
  longint exp_d [$];
  bit     exp_l [$];
  int     exp_px [$];
  longint got_d [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  convolver_stream #(.DATA_WIDTH(16), .IMAGE_SIZE(6), .KERNEL_SIZE(3), .STRIDE(1)) dut_a (
    .clk(clk), .rstn(rstn), .weight_we(we_v[0]), .weight_addr(weight_addr[3:0]),
    .weight_data(weight_data), .weight_err(a_err), .in_valid(iv_v[0]), .in_ready(a_rdy),
    .in_data(in_data), .out_valid(a_ov), .out_ready(out_ready), .out_data(a_od),
    .out_last(a_ol), .busy(a_busy));

  convolver_stream #(.DATA_WIDTH(16), .IMAGE_SIZE(7), .KERNEL_SIZE(3), .STRIDE(2)) dut_s (
    .clk(clk), .rstn(rstn), .weight_we(we_v[1]), .weight_addr(weight_addr[3:0]),
    .weight_data(weight_data), .weight_err(s_err), .in_valid(iv_v[1]), .in_ready(s_rdy),
    .in_data(in_data), .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od),
    .out_last(s_ol), .busy(s_busy));

  convolver_stream dut_b (
    .clk(clk), .rstn(rstn), .weight_we(we_v[2]), .weight_addr(weight_addr),
    .weight_data(weight_data), .weight_err(b_err), .in_valid(iv_v[2]), .in_ready(b_rdy),
    .in_data(in_data), .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .out_last(b_ol), .busy(b_busy));

  always_comb begin
    iv_v = '0;
    we_v = '0;
    iv_v[sel] = in_valid;
    we_v[sel] = weight_we;
    case (sel)
      1: begin
        m_err = s_err; m_rdy = s_rdy; m_ov = s_ov; m_ol = s_ol; m_busy = s_busy;
        m_od = {s_od[35], s_od};
      end
      2: begin
        m_err = b_err; m_rdy = b_rdy; m_ov = b_ov; m_ol = b_ol; m_busy = b_busy;
        m_od = b_od;
      end
      default: begin
        m_err = a_err; m_rdy = a_rdy; m_ov = a_ov; m_ol = a_ol; m_busy = a_busy;
        m_od = {a_od[35], a_od};
      end
    endcase
  end

  task automatic check(input string nm, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int rnd16();
    logic signed [15:0] v;
    v = 16'($urandom);
    return int'(v);
  endfunction

  task automatic set_cfg(input int s);
    sel = s;
    case (s)
      1:       begin cn = 7;  ck = 3; cs = 2; end
      2:       begin cn = 28; ck = 5; cs = 1; end
      default: begin cn = 6;  ck = 3; cs = 1; end
    endcase
  endtask

  // golden model: enumerate output windows straight from the stride grid
  function automatic void build_model(input int nf);
    int m, r, c, nn;
    longint sum;
    exp_d.delete(); exp_l.delete(); exp_px.delete();
    m  = (cn - ck) / cs + 1;
    nn = cn * cn;
    for (int f = 0; f < nf; f++)
      for (int orow = 0; orow < m; orow++)
        for (int ocol = 0; ocol < m; ocol++) begin
          r = ck - 1 + orow * cs;
          c = ck - 1 + ocol * cs;
          sum = 0;
          for (int kr = 0; kr < ck; kr++)
            for (int kc = 0; kc < ck; kc++)
              sum += wt[kr*ck+kc] * longint'(pix[f*nn + (r-ck+1+kr)*cn + (c-ck+1+kc)]);
          exp_d.push_back(sum);
          exp_l.push_back((orow == m-1) && (ocol == m-1));
          exp_px.push_back(f*nn + r*cn + c);
        end
  endfunction

  task automatic wr(input int addr, input longint data, input bit exp_err, input string nm);
    weight_we   = 1'b1;
    weight_addr = addr[4:0];
    weight_data = data[15:0];
    @(posedge clk); #1;
    weight_we = 1'b0;
    @(negedge clk);
    check(nm, m_err, exp_err);
    @(posedge clk); #1;
  endtask

  task automatic load_weights();
    for (int i = 0; i < ck*ck; i++) wr(i, wt[i], 1'b0, "weight_load_err");
  endtask

  task automatic drive(input int mode, input int nf);
    bit done, abort;
    int w;
    abort = 1'b0;
    for (int i = 0; i < nf*cn*cn && !abort; i++) begin
      if (mode == 2 && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = pix[i][15:0];
      done = 1'b0;
      w = 0;
      while (!done) begin
        @(negedge clk);
        if (i == 1 && w == 0) check("busy_run", m_busy, 1);
        if (m_rdy) begin
          done = 1'b1;
          acc_cyc[i] = cyc;
        end
        @(posedge clk); #1;
        w++;
        if (!done && w > 400) begin
          check("pixel_accept_timeout", 0, 1);
          done  = 1'b1;
          abort = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int mode, input int nf);
    int hold, budget, idx;
    hold = 0;
    budget = 0;
    out_ready = 1'b1;
    while (got_d.size() < exp_d.size() && budget < 8*nf*cn*cn + 200) begin
      @(negedge clk);
      budget++;
      if (m_ov && out_ready) begin
        idx = got_d.size();
        check("result_data", m_od, exp_d[idx]);
        check("result_last", m_ol, exp_l[idx]);
        if (mode == 0) check("result_latency", cyc, acc_cyc[exp_px[idx]] + 1);
        got_d.push_back(m_od);
      end
      @(posedge clk); #1;
      case (mode)
        1: if (got_d.size() >= 3 && hold < 20) begin out_ready = 1'b0; hold++; end
           else out_ready = 1'b1;
        2: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
    end
    out_ready = 1'b1;
    check("result_count", got_d.size(), exp_d.size());
  endtask

  task automatic run_frame(input int mode, input int nf);
    build_model(nf);
    got_d.delete();
    fork
      drive(mode, nf);
      collect(mode, nf);
    join
    repeat (3) begin
      @(negedge clk);
      check("no_extra_result", m_ov, 0);
      @(posedge clk); #1;
    end
    check("busy_idle", m_busy, 0);
  endtask

  // stalled result must hold steady and block the input
  logic signed [36:0] pv_d;
  logic               pv_l;
  bit                 pv_stall = 1'b0;
  always @(negedge clk) begin
    if (!rstn) begin
      pv_stall <= 1'b0;
    end else begin
      if (pv_stall) begin
        check("stall_valid_held", m_ov, 1);
        check("stall_data_held", m_od, pv_d);
        check("stall_last_held", m_ol, pv_l);
      end
      if (m_ov && !out_ready) check("stall_in_ready_low", m_rdy, 0);
      pv_stall <= m_ov && !out_ready;
      pv_d     <= m_od;
      pv_l     <= m_ol;
    end
  end

  typedef struct {
    int     cfg;
    int     wmode;    // 1: all +1, 2: all -1
    int     pmode;    // 0: r*N+c ramp, 1: all 1, 2: all 32767
    int     mode;     // 0: out_ready=1, 1: 20-cycle stall, 2: random gaps/backpressure
    int     nf;
    int     cnt;
    longint first;
    longint second;
    longint final_v;
  } vec_t;

  initial begin
    vec_t tv [6];
    tv[0] = '{0, 1, 0, 0, 1, 16, 63, 72, 252};
    tv[1] = '{1, 1, 1, 0, 1, 9, 9, 9, 9};
    tv[2] = '{0, 2, 2, 0, 1, 16, -294903, -294903, -294903};
    tv[3] = '{0, 1, 0, 1, 1, 16, 63, 72, 252};
    tv[4] = '{0, 1, 0, 2, 1, 16, 63, 72, 252};
    tv[5] = '{0, 1, 0, 0, 2, 32, 63, 72, 252};

    rstn = 1'b0; weight_we = 1'b0; weight_addr = '0; weight_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    set_cfg(0);
    repeat (2) @(negedge clk);
    check("reset_out_valid", a_ov | s_ov | b_ov, 0);
    check("reset_out_data", m_od, 0);
    check("reset_out_last", a_ol | s_ol | b_ol, 0);
    check("reset_weight_err", a_err | s_err | b_err, 0);
    check("reset_busy", a_busy | s_busy | b_busy, 0);
    check("reset_in_ready", m_rdy, 1);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) begin
      set_cfg(tv[t].cfg);
      for (int i = 0; i < ck*ck; i++) wt[i] = (tv[t].wmode == 2) ? -1 : 1;
      load_weights();
      for (int f = 0; f < tv[t].nf; f++)
        for (int r = 0; r < cn; r++)
          for (int c = 0; c < cn; c++)
            pix[f*cn*cn + r*cn + c] = (tv[t].pmode == 0) ? r*cn + c :
                                      (tv[t].pmode == 1) ? 1 : 32767;
      run_frame(tv[t].mode, tv[t].nf);
      check($sformatf("vec%0d_count", t), got_d.size(), tv[t].cnt);
      check($sformatf("vec%0d_first", t), got_d[0], tv[t].first);
      check($sformatf("vec%0d_second", t), got_d[1], tv[t].second);
      check($sformatf("vec%0d_final", t), got_d[got_d.size()-1], tv[t].final_v);
    end

    // writes colliding with the first pixel and landing mid-frame are both refused
    set_cfg(0);
    for (int i = 0; i < 36; i++) pix[i] = rnd16();
    fork
      run_frame(0, 1);
      begin
        wr(0, 5, 1'b1, "we_first_pixel");
        repeat (10) @(posedge clk);
        #1;
        wr(2, 7, 1'b1, "we_during_run");
      end
    join

    // out-of-range address refused; centre weight update shows in the next frame
    wr(9, 3, 1'b1, "we_addr_range");
    wr(4, 10, 1'b0, "we_centre");
    wt[4] = 10;
    for (int i = 0; i < 36; i++) pix[i] = rnd16();
    run_frame(2, 1);

    // reset with a result pending mid-frame
    for (int i = 0; i < 21; i++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("midframe_pending", m_ov, 1);
    check("midframe_busy", m_busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_valid", m_ov, 0);
    check("async_reset_data", m_od, 0);
    check("async_reset_busy", m_busy, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 25; i++) wt[i] = 0;
    for (int i = 0; i < 36; i++) pix[i] = rnd16();
    run_frame(0, 1);
    check("post_reset_zero", got_d[5], 0);

    // default geometry, random weights and pixels, random flow control
    set_cfg(2);
    for (int i = 0; i < 25; i++) wt[i] = rnd16();
    load_weights();
    for (int i = 0; i < 784; i++) pix[i] = rnd16();
    run_frame(2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
